// File: rtl/alu_seq_unit.sv
// Handshaked sequential ALU: one request in, one result plus flags out.
// Shifts iterate one bit per cycle unless ALU_SEQ_BARREL_SHIFT_EN selects a single-cycle barrel shifter.
module alu_seq_unit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        aluc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] r,
  output logic              zero,
  output logic              carry,
  output logic              negative,
  output logic              overflow
);

`ifdef ALU_SEQ_BARREL_SHIFT_EN
  localparam bit ITER_SHIFT = 1'b0;
`else
  localparam bit ITER_SHIFT = 1'b1;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic              carry;
    logic              ovf;
  } alu_res_t;

  state_t             state, state_nxt;
  logic [SHAMT_W-1:0] cnt;
  logic [3:0]         op;
  alu_res_t           comb_res;
  logic [DATA_W-1:0]  step_r;
  logic               step_out;
  logic               accept;
  logic               start_shift;

  // Single-cycle result for every opcode; in the iterative build a shift here only covers shamt=0.
  function automatic alu_res_t compute(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                                       input logic [3:0] opc);
    alu_res_t         res;
    logic [DATA_W:0]  sum;
    logic [DATA_W:0]  diff;
    res  = '0;
    sum  = {1'b0, x} + {1'b0, y};
    diff = {1'b0, x} - {1'b0, y};
    unique case (opc)
      4'b0000: begin res.r = sum[DATA_W-1:0];  res.carry = sum[DATA_W]; end
      4'b0010: begin
        res.r     = sum[DATA_W-1:0];
        res.carry = sum[DATA_W];
        res.ovf   = (x[DATA_W-1] == y[DATA_W-1]) && (sum[DATA_W-1] != x[DATA_W-1]);
      end
      4'b0001: begin res.r = diff[DATA_W-1:0]; res.carry = diff[DATA_W]; end
      4'b0011: begin
        res.r     = diff[DATA_W-1:0];
        res.carry = diff[DATA_W];
        res.ovf   = (x[DATA_W-1] != y[DATA_W-1]) && (diff[DATA_W-1] != x[DATA_W-1]);
      end
      4'b0100: res.r = x & y;
      4'b0101: res.r = x | y;
      4'b0110: res.r = x ^ y;
      4'b0111: res.r = ~(x | y);
      4'b1000, 4'b1001: res.r = {y[15:0], {(DATA_W-16){1'b0}}};
      4'b1010: begin res.r = DATA_W'(diff[DATA_W]); res.carry = diff[DATA_W]; end
      4'b1011: res.r = DATA_W'($signed(x) < $signed(y));
      default: begin
`ifdef ALU_SEQ_BARREL_SHIFT_EN
        if (opc == 4'b1100)      {res.r, res.carry} = $signed({y, 1'b0}) >>> x[SHAMT_W-1:0];
        else if (opc == 4'b1101) {res.r, res.carry} = {y, 1'b0} >> x[SHAMT_W-1:0];
        else                     {res.carry, res.r} = {1'b0, y} << x[SHAMT_W-1:0];
`else
        res.r = y;
`endif
      end
    endcase
    return res;
  endfunction

  assign comb_res    = compute(a, b, aluc);
  assign accept      = req_valid && req_ready;
  assign start_shift = ITER_SHIFT && (aluc[3:2] == 2'b11) && (a[SHAMT_W-1:0] != '0);

  // One-bit step of the iterative shifter; the carry is the bit leaving the word.
  always_comb begin
    step_r   = {1'b0, r[DATA_W-1:1]};
    step_out = r[0];
    if (op[3:1] == 3'b111)  {step_out, step_r} = {r, 1'b0};
    else if (op == 4'b1100) step_r = {r[DATA_W-1], r[DATA_W-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = !rst;
        if (accept) state_nxt = start_shift ? SHIFT : DONE;
      end
      SHIFT: if (cnt == SHAMT_W'(1)) state_nxt = DONE;
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r        <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
      cnt      <= '0;
      op       <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          op <= aluc;
          if (start_shift) begin
            r        <= b;
            cnt      <= a[SHAMT_W-1:0];
            zero     <= 1'b0;
            carry    <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
          end else begin
            r        <= comb_res.r;
            zero     <= (comb_res.r == '0);
            carry    <= comb_res.carry;
            negative <= comb_res.r[DATA_W-1];
            overflow <= comb_res.ovf;
          end
        end
        SHIFT: begin
          r     <= step_r;
          carry <= step_out;
          cnt   <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            zero     <= (step_r == '0);
            negative <= step_r[DATA_W-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
